// File: rtl/seq_sam_mult_pkg.sv
// Shared definitions for the sequential shift-and-accumulate multiplier:
// FSM state encodings and the default operand width.
package seq_sam_mult_pkg;

    localparam int unsigned SAM_WIDTH = 32;

    typedef enum logic [1:0] {
        SAM_IDLE = 2'd0,
        SAM_RUN  = 2'd1,
        SAM_FIX  = 2'd2
    } sam_state_t;

endpackage

// File: rtl/seq_sam_mult_step.sv
// One shift-and-accumulate iteration (combinational).
// Ports:
//   prod      in  2*WIDTH  running {upper accumulator, remaining multiplier bits}
//   mag_a     in  WIDTH    multiplicand magnitude
//   prod_next out 2*WIDTH  prod after conditional add and right shift
module seq_sam_mult_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   mag_a,
    output logic [2*WIDTH-1:0] prod_next
);

    logic [WIDTH:0] sum;

    // Carry out of the add lands in the MSB after the shift.
    always_comb begin
        sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
        if (prod[0]) begin
            sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
        end
        prod_next = {sum, prod[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_sam_mult.sv
// Multi-cycle signed/unsigned shift-and-accumulate multiplier, one
// multiplier bit per clock, start/ready/done handshake.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       request, accepted only while ready=1
//   is_signed   1 = two's-complement operands (sampled with start)
//   a, b        WIDTH-bit operands (sampled with start)
//   ready       high while idle
//   done        one-cycle pulse when result is valid
//   result      2*WIDTH-bit product, held until the next completion
module seq_sam_mult
    import seq_sam_mult_pkg::*;
#(
    parameter int unsigned WIDTH = SAM_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    sam_state_t       state;
    logic [WIDTH-1:0] mag_a;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    prod_next;
    logic             neg;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;
    logic             neg_c;

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned.
    always_comb begin
        abs_a_c = a;
        abs_b_c = b;
        if (is_signed && a[WIDTH-1]) abs_a_c = ~a + WIDTH'(1);
        if (is_signed && b[WIDTH-1]) abs_b_c = ~b + WIDTH'(1);
        // A zero magnitude forces a non-negative result (no negative zero).
        neg_c = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]) & (|abs_a_c) & (|abs_b_c);
    end

    seq_sam_mult_step #(.WIDTH(WIDTH)) u_step (
        .prod      (prod),
        .mag_a     (mag_a),
        .prod_next (prod_next)
    );

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SAM_IDLE;
            mag_a  <= '0;
            prod   <= '0;
            neg    <= 1'b0;
            count  <= '0;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                SAM_IDLE: begin
                    if (start) begin
                        mag_a <= abs_a_c;
                        prod  <= {{WIDTH{1'b0}}, abs_b_c};
                        neg   <= neg_c;
                        count <= '0;
                        ready <= 1'b0;
                        state <= SAM_RUN;
                    end
                end
                SAM_RUN: begin
                    prod  <= prod_next;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= SAM_FIX;
                    end
                end
                SAM_FIX: begin
                    result <= neg ? (~prod + PW'(1)) : prod;
                    done   <= 1'b1;
                    ready  <= 1'b1;
                    state  <= SAM_IDLE;
                end
                default: begin
                    state <= SAM_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sam_mult.sv
// Self-checking bench: WIDTH=32 and WIDTH=8 instances, directed table,
// handshake/reset sequences and random operands against an arithmetic model.
module tb_seq_sam_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start32 = 1'b0, sg32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        ready32, done32;
    logic [63:0] result32;

    logic        start8 = 1'b0, sg8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready8, done8;
    logic [15:0] result8;

    seq_sam_mult #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .is_signed(sg32),
        .a(a32), .b(b32), .ready(ready32), .done(done32), .result(result32));

    seq_sam_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sg8),
        .a(a8), .b(b8), .ready(ready8), .done(done8), .result(result8));

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          w8;
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference products computed with plain wide arithmetic.
    function automatic logic [63:0] ref32(input bit s, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    function automatic logic [15:0] ref8(input bit s, input logic [7:0] x, input logic [7:0] y);
        int sx, sy;
        if (s) begin
            sx = int'($signed(x));
            sy = int'($signed(y));
        end else begin
            sx = int'({24'd0, x});
            sy = int'({24'd0, y});
        end
        return 16'(sx * sy);
    endfunction

    // Callers must be off the clock edge when issuing.
    task automatic issue32(input bit s, input logic [31:0] x, input logic [31:0] y);
        sg32 = s; a32 = x; b32 = y; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom; sg32 = ~s;
    endtask

    task automatic issue8(input bit s, input logic [7:0] x, input logic [7:0] y);
        sg8 = s; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sg8 = ~s;
    endtask

    // Returns edges from accept to done (-1 on timeout) and ready-low samples.
    task automatic wait32(output logic [63:0] res, output int lat, output int rlow);
        lat = -1; res = '0;
        rlow = ready32 ? 0 : 1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (!ready32) rlow++;
            if (done32) begin lat = k; res = result32; break; end
        end
    endtask

    task automatic wait8(output logic [15:0] res, output int lat);
        lat = -1; res = '0;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (done8) begin lat = k; res = result8; break; end
        end
    endtask

    vec_t        vecs[$];
    logic [63:0] r64;
    logic [15:0] r16;
    int          lat, rlow, dones;
    logic [31:0] ra, rb;
    logic [7:0]  qa, qb;
    bit          rs;

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vecs.push_back('{0, 1, 32'd50, -32'sd40, 64'hFFFF_FFFF_FFFF_F830});
        vecs.push_back('{0, 1, -32'sd80, -32'sd65, 64'h0000_0000_0000_1450});
        vecs.push_back('{0, 1, -32'sd999, 32'd999, 64'hFFFF_FFFF_FFF0_C58F});
        vecs.push_back('{0, 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
        vecs.push_back('{0, 0, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE});
        vecs.push_back('{0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{0, 1, 32'd98756, 32'd0, 64'h0});
        vecs.push_back('{0, 1, 32'd0, -32'sd5, 64'h0});
        vecs.push_back('{0, 1, -32'sd1, -32'sd1, 64'h1});
        vecs.push_back('{1, 1, 32'h80, 32'h7F, 64'hC080});
        vecs.push_back('{1, 0, 32'hFF, 32'hFF, 64'hFE01});
        vecs.push_back('{1, 1, 32'h80, 32'h80, 64'h4000});
        vecs.push_back('{1, 1, 32'h00, 32'h85, 64'h0});

        // Reset state.
        #12;
        chk("reset_ready32", 64'(ready32), 64'd1);
        chk("reset_done32", 64'(done32), 64'd0);
        chk("reset_result32", result32, 64'd0);
        chk("reset_result8", 64'(result8), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Directed table; consecutive entries issue on the done cycle.
        foreach (vecs[i]) begin
            if (vecs[i].w8) begin
                issue8(vecs[i].s, vecs[i].a[7:0], vecs[i].b[7:0]);
                wait8(r16, lat);
                chk($sformatf("vec%0d_result8", i), 64'(r16), vecs[i].exp);
                chk($sformatf("vec%0d_latency8", i), 64'(lat), 64'd9);
            end else begin
                issue32(vecs[i].s, vecs[i].a, vecs[i].b);
                wait32(r64, lat, rlow);
                chk($sformatf("vec%0d_result32", i), r64, vecs[i].exp);
                chk($sformatf("vec%0d_latency32", i), 64'(lat), 64'd33);
                chk($sformatf("vec%0d_readylow32", i), 64'(rlow), 64'd33);
            end
        end
        @(posedge clk); #1;
        chk("done_is_pulse32", 64'(done32), 64'd0);

        // Start during RUN is ignored; exactly one done.
        issue32(1'b1, 32'd1234, -32'sd77);
        repeat (5) @(posedge clk);
        #1;
        sg32 = 1'b0; a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        dones = 0; r64 = '0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (done32) begin dones++; r64 = result32; end
        end
        chk("ignored_start_result", r64, ref32(1'b1, 32'd1234, -32'sd77));
        chk("ignored_start_dones", 64'(dones), 64'd1);

        // Reset mid-operation aborts with no done.
        issue32(1'b1, 32'd50000, -32'sd3);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(ready32), 64'd1);
        chk("midrst_done", 64'(done32), 64'd0);
        chk("midrst_result", result32, 64'd0);
        dones = 0;
        repeat (3) begin @(posedge clk); #1; if (done32) dones++; end
        @(negedge clk); rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (done32) dones++; end
        chk("midrst_no_done", 64'(dones), 64'd0);
        issue32(1'b1, 32'd50000, -32'sd3);
        wait32(r64, lat, rlow);
        chk("postrst_result", r64, 64'hFFFF_FFFF_FFFD_B610);
        chk("postrst_latency", 64'(lat), 64'd33);

        // Random 32-bit operands against the model.
        for (int n = 0; n < 150; n++) begin
            rs = 1'($urandom); ra = pick32(); rb = pick32();
            issue32(rs, ra, rb);
            wait32(r64, lat, rlow);
            chk($sformatf("rnd32 s=%0d a=%h b=%h", rs, ra, rb), r64, ref32(rs, ra, rb));
        end

        // Random 8-bit operands in both modes.
        for (int n = 0; n < 800; n++) begin
            rs = 1'(n & 1); qa = 8'($urandom); qb = 8'($urandom);
            issue8(rs, qa, qb);
            wait8(r16, lat);
            chk($sformatf("rnd8 s=%0d a=%h b=%h", rs, qa, qb), 64'(r16), 64'(ref8(rs, qa, qb)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
